hf_mode_sequencer: RTL and testbench
====================================

// Module: hf_mode_sequencer
// PURPOSE
// - Owns the FPGA configuration word and major-mode select that drive the HF mode output muxes.
// - Oversamples the ARM SPI link (spck/mosi/ncs) in the ck_1356meg domain and decodes command frames.
// - Changes major mode glitch-free: quiesce coil drivers, wait a guard interval, commit, then settle.
// - Minor-only changes (same major mode) commit immediately; the carrier is never cut for them.
// PARAMETERS
// GUARD_CYCLES   16  cycles quiesce is held before a major-mode commit (>=1)
// SETTLE_CYCLES  64  cycles after commit before mode_ready re-asserts (>=1)
// CNT_W          8   width of guard/settle counter; must hold max(GUARD,SETTLE)
// PORTS
// ck_1356meg  in   1  sole clock, 13.56 MHz; all logic on its rising edge
// nreset      in   1  asynchronous, active-low reset
// spck        in   1  SPI clock from ARM (async; must be <= ck_1356meg/4)
// mosi        in   1  SPI data, sampled on spck rising edge
// ncs         in   1  SPI chip select, active low, frames one command
// major_mode  out  3  committed major mode to output muxes (111 = all off)
// minor_cfg   out  5  committed conf_word[4:0] (modulation/correlator/sim bits)
// quiesce     out  1  1 = force pwr_* and pwr_oe* low downstream
// mode_ready  out  1  1 = committed mode is settled and valid
// busy        out  1  1 = FSM not in IDLE or a command is pending
// cmd_err     out  1  one-cycle pulse: frame ended with bit count != 16
// BEHAVIOUR
// - Reset (async assert, sync-released): major_mode=3'b111, minor_cfg=0, quiesce=0, mode_ready=1,
//   busy=0, cmd_err=0, FSM=IDLE, pending cleared, shift reg and bit count cleared.
// - Input sync: spck/mosi/ncs each pass 2 flops; edges detected on synced copies.
// - Shift: on synced spck rise while synced ncs low: shift_reg <= {shift_reg[14:0], mosi_s};
//   bit_cnt saturates at 17. Synced ncs fall clears bit_cnt.
// - Frame end = cycle F where synced ncs rises. bit_cnt!=16 -> cmd_err=1 at F+1, no state change.
//   bit_cnt==16 and shift_reg[15:12]==4'b0001 -> request {major=sr[7:5], minor=sr[4:0]};
//   any other opcode silently ignored.
// - FSM IDLE: request with major==major_mode -> minor_cfg updated at F+1, stays IDLE, mode_ready
//   stays 1. Request with new major -> QUIESCE at F+1: quiesce=1, mode_ready=0, cnt=0.
// - QUIESCE: after GUARD_CYCLES cycles -> COMMIT.
// - COMMIT (1 cycle): major_mode/minor_cfg <= request; quiesce=0 next cycle -> SETTLE.
// - SETTLE: SETTLE_CYCLES cycles, mode_ready=0; then mode_ready=1 -> IDLE.
// - Switching to 3'b111: same sequence; quiesce drops at commit (mux outputs are 0 anyway).
// - Request during QUIESCE/COMMIT/SETTLE: stored in one-deep pending slot (newer overwrites older);
//   on return to IDLE it is processed as a fresh request in the same cycle. Current switch never aborted.
// - Frame end and pending service in same IDLE cycle: frame request wins, pending discarded.
// - Reset mid-operation: all outputs return to reset values asynchronously; pending lost.
// - busy = (state!=IDLE) | pending_valid.
// TESTING
// - Reset -> major_mode=111, minor_cfg=0, quiesce=0, mode_ready=1, busy=0.
// - From reset send 0x1041 -> quiesce=1 for 16 cycles, major_mode=010, minor_cfg=00001,
//   mode_ready=1 64 cycles after commit.
// - In mode 010 send 0x1042 -> minor_cfg=00010 at F+1; quiesce and mode_ready never toggle.
// - 12-bit frame, then 17-bit frame -> cmd_err pulse each at F+1; outputs unchanged.
// - 0x1041 then 0x1061 mid-QUIESCE then 0x1081 mid-SETTLE -> 010 committed, then only 100 applied.
// - Assert nreset mid-QUIESCE -> major_mode=111, quiesce=0, mode_ready=1 without clock edge.

Source files
------------

// File: rtl/hf_mode_sequencer.sv
// HF mode sequencer: decodes ARM SPI command frames and applies FPGA mode changes,
// quiescing the coil drivers around every major-mode switch.
module hf_mode_sequencer #(
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic [2:0] major_mode,
  output logic [4:0] minor_cfg,
  output logic       quiesce,
  output logic       mode_ready,
  output logic       busy,
  output logic       cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_COMMIT, S_SETTLE} state_t;

  // COMMIT is the last quiesced cycle, so QUIESCE itself lasts GUARD_CYCLES-1 cycles
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES >= 2 ? GUARD_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic spck_meta_q, spck_s_q, spck_prev_q;
  logic ncs_meta_q, ncs_s_q, ncs_prev_q;
  logic mosi_meta_q, mosi_s_q;

  logic [15:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       major_q, major_d;
  logic [4:0]       minor_q, minor_d;
  logic             quiesce_q, quiesce_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_req_q, pend_req_d;
  logic [7:0]       req_q, req_d;

  logic       spck_rise, ncs_rise, ncs_fall;
  logic       frame_bad, frame_req;
  logic       svc_valid;
  logic [7:0] svc_req;
  logic       sr_unused;

  assign spck_rise = spck_s_q & ~spck_prev_q;
  assign ncs_rise  = ncs_s_q & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s_q & ncs_prev_q;
  assign frame_bad = ncs_rise && (bit_cnt_q != 5'd16);
  assign frame_req = ncs_rise && (bit_cnt_q == 5'd16) && (shift_q[15:12] == 4'b0001);
  assign sr_unused = ^shift_q[11:8];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (ncs_fall) bit_cnt_d = '0;
    if (spck_rise && !ncs_s_q) begin
      shift_d = {shift_q[14:0], mosi_s_q};
      if (bit_cnt_d != 5'd17) bit_cnt_d = bit_cnt_d + 5'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    major_d    = major_q;
    minor_d    = minor_q;
    quiesce_d  = quiesce_q;
    ready_d    = ready_q;
    err_d      = frame_bad;
    pend_d     = pend_q;
    pend_req_d = pend_req_q;
    req_d      = req_q;
    svc_valid  = 1'b0;
    svc_req    = pend_req_q;
    case (state_q)
      S_IDLE: begin
        // a frame ending this cycle supersedes whatever is pending
        if (frame_req) begin
          svc_valid = 1'b1;
          svc_req   = shift_q[7:0];
        end else if (pend_q) begin
          svc_valid = 1'b1;
        end
        pend_d = 1'b0;
        if (svc_valid) begin
          if (svc_req[7:5] == major_q) begin
            minor_d = svc_req[4:0];
          end else begin
            req_d     = svc_req;
            quiesce_d = 1'b1;
            ready_d   = 1'b0;
            cnt_d     = '0;
            state_d   = (GUARD_CYCLES < 2) ? S_COMMIT : S_QUIESCE;
          end
        end
      end
      S_QUIESCE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GUARD_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        major_d   = req_q[7:5];
        minor_d   = req_q[4:0];
        quiesce_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SETTLE_LAST) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && frame_req) begin
      pend_d     = 1'b1;
      pend_req_d = shift_q[7:0];
    end
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      spck_meta_q <= 1'b0;
      spck_s_q    <= 1'b0;
      spck_prev_q <= 1'b0;
      ncs_meta_q  <= 1'b1;
      ncs_s_q     <= 1'b1;
      ncs_prev_q  <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      major_q     <= 3'b111;
      minor_q     <= '0;
      quiesce_q   <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_req_q  <= '0;
      req_q       <= '0;
    end else begin
      spck_meta_q <= spck;
      spck_s_q    <= spck_meta_q;
      spck_prev_q <= spck_s_q;
      ncs_meta_q  <= ncs;
      ncs_s_q     <= ncs_meta_q;
      ncs_prev_q  <= ncs_s_q;
      mosi_meta_q <= mosi;
      mosi_s_q    <= mosi_meta_q;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      major_q     <= major_d;
      minor_q     <= minor_d;
      quiesce_q   <= quiesce_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_req_q  <= pend_req_d;
      req_q       <= req_d;
    end
  end

  assign major_mode = major_q;
  assign minor_cfg  = minor_q;
  assign quiesce    = quiesce_q;
  assign mode_ready = ready_q;
  assign cmd_err    = err_q;
  assign busy       = (state_q != S_IDLE) | pend_q;

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Bench for hf_mode_sequencer: frame-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_hf_mode_sequencer;
  localparam int GUARD  = 100;
  localparam int SETTLE = 120;

  logic clk = 1'b0, nreset = 1'b0, spck = 1'b0, mosi = 1'b0, ncs = 1'b1;
  logic [2:0] major_mode, d_major;
  logic [4:0] minor_cfg, d_minor;
  logic quiesce, mode_ready, busy, cmd_err;
  logic d_quiesce, d_ready, d_busy, d_err;

  always #5 clk = ~clk;

  // long guard/settle so a whole frame fits inside each phase
  hf_mode_sequencer #(.GUARD_CYCLES(GUARD), .SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .ck_1356meg(clk), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
    .major_mode(major_mode), .minor_cfg(minor_cfg), .quiesce(quiesce),
    .mode_ready(mode_ready), .busy(busy), .cmd_err(cmd_err));

  hf_mode_sequencer u_def (
    .ck_1356meg(clk), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs),
    .major_mode(d_major), .minor_cfg(d_minor), .quiesce(d_quiesce),
    .mode_ready(d_ready), .busy(d_busy), .cmd_err(d_err));

  int tests = 0, fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit ok; bit bad; int req; } ev_t;
  ev_t e1, e2, en;
  int  m_major, m_minor, m_q, m_rdy, m_err, m_sw, m_t, m_pend, m_preq, m_req;
  int  bits[$];
  logic p_spck, p_ncs;

  task automatic model_reset();
    m_major = 7; m_minor = 0; m_q = 0; m_rdy = 1; m_err = 0;
    m_sw = 0; m_t = 0; m_pend = 0; m_preq = 0; m_req = 0;
    bits.delete();
    p_spck = 1'b0; p_ncs = 1'b1;
    e1 = '{default: 0}; e2 = '{default: 0};
  endtask

  task automatic step(input ev_t ev);
    int have, r;
    have = 0; r = 0;
    m_err = ev.bad;
    if (m_sw == 0) begin
      if (ev.ok) begin have = 1; r = ev.req; end
      else if (m_pend != 0) begin have = 1; r = m_preq; end
      m_pend = 0;
      if (have != 0) begin
        if ((r >> 5) == m_major) m_minor = r & 31;
        else begin m_sw = 1; m_t = 0; m_req = r; m_rdy = 0; end
      end
    end else begin
      if (ev.ok) begin m_pend = 1; m_preq = ev.req; end
      m_t++;
      if (m_t == GUARD) begin m_major = m_req >> 5; m_minor = m_req & 31; end
      if (m_t == GUARD + SETTLE) begin m_sw = 0; m_rdy = 1; end
    end
    m_q = (m_sw != 0 && m_t < GUARD) ? 1 : 0;
  endtask

  initial model_reset();

  // inputs seen at edge k take effect on outputs after edge k+2 (two-flop sync)
  always @(posedge clk) begin
    if (!nreset) model_reset();
    else begin
      int w;
      en = '{default: 0};
      if (spck && !p_spck && !ncs) bits.push_back(int'(mosi));
      if (!ncs && p_ncs) bits.delete();
      if (ncs && !p_ncs) begin
        if (bits.size() != 16) en.bad = 1'b1;
        else begin
          w = 0;
          foreach (bits[i]) w = (w << 1) | bits[i];
          if (((w >> 12) & 15) == 1) begin en.ok = 1'b1; en.req = w & 255; end
        end
      end
      p_spck = spck; p_ncs = ncs;
      step(e2);
      e2 = e1; e1 = en;
    end
  end

  always @(negedge clk) begin
    if (nreset) begin
      check("major_mode", int'(major_mode), m_major);
      check("minor_cfg",  int'(minor_cfg),  m_minor);
      check("quiesce",    int'(quiesce),    m_q);
      check("mode_ready", int'(mode_ready), m_rdy);
      check("cmd_err",    int'(cmd_err),    m_err);
      check("busy",       int'(busy),       (m_sw != 0 || m_pend != 0) ? 1 : 0);
    end
  end

  // ---------------- monitors for literal checks ----------------
  int hist[$];
  int prev_major = 7, prev_q = 0, q_rise = 0, q_hi = 0, err_cnt = 0, seen_011 = 0;
  int d_q_hi = 0, d_nrdy = 0;
  always @(negedge clk) begin
    if (!nreset) begin
      prev_major = 7; prev_q = 0;
    end else begin
      if (int'(major_mode) != prev_major) hist.push_back(int'(major_mode));
      prev_major = int'(major_mode);
      if (major_mode == 3'b011) seen_011 = 1;
      if (quiesce && prev_q == 0) q_rise++;
      if (quiesce) q_hi++;
      prev_q = int'(quiesce);
      if (cmd_err) err_cnt++;
      if (d_quiesce) d_q_hi++;
      if (!d_ready) d_nrdy++;
    end
  end

  task automatic send_frame(input logic [16:0] w, input int n);
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      repeat (2) @(negedge clk);
      spck = 1'b1;
      repeat (2) @(negedge clk);
      spck = 1'b0;
    end
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;
    @(negedge clk);
    check("rst_major", int'(major_mode), 7);
    check("rst_minor", int'(minor_cfg), 0);
    check("rst_quiesce", int'(quiesce), 0);
    check("rst_ready", int'(mode_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(cmd_err), 0);

    // major switch 111 -> 010
    send_frame(17'h01041, 16);
    repeat (GUARD + SETTLE + 20) @(negedge clk);
    check("sw1_major", int'(major_mode), 2);
    check("sw1_minor", int'(minor_cfg), 1);
    check("sw1_ready", int'(mode_ready), 1);
    check("sw1_qhi", q_hi, GUARD);
    check("def_major", int'(d_major), 2);
    check("def_quiesce_cycles", d_q_hi, 16);
    check("def_notready_cycles", d_nrdy, 80);

    // minor-only change
    send_frame(17'h01042, 16);
    repeat (10) @(negedge clk);
    check("minor_only_minor", int'(minor_cfg), 2);
    check("minor_only_major", int'(major_mode), 2);
    check("minor_only_qrise", q_rise, 1);
    check("def_minor_only_nrdy", d_nrdy, 80);

    // malformed frames
    send_frame(17'h00041, 12);
    send_frame(17'h01041, 17);
    repeat (10) @(negedge clk);
    check("bad_err_pulses", err_cnt, 2);
    check("bad_minor", int'(minor_cfg), 2);
    check("bad_qrise", q_rise, 1);

    // go to 111, then the pending-overwrite sequence
    send_frame(17'h010E1, 16);
    repeat (GUARD + SETTLE + 20) @(negedge clk);
    check("off_major", int'(major_mode), 7);
    hist.delete();
    send_frame(17'h01041, 16);
    send_frame(17'h01061, 16);
    check("mid_quiesce", int'(quiesce), 1);
    send_frame(17'h01081, 16);
    check("mid_settle_q", int'(quiesce), 0);
    check("mid_settle_rdy", int'(mode_ready), 0);
    repeat (2 * (GUARD + SETTLE) + 40) @(negedge clk);
    check("seq_major", int'(major_mode), 4);
    check("seq_changes", hist.size(), 2);
    if (hist.size() == 2) begin
      check("seq_first", hist[0], 2);
      check("seq_second", hist[1], 4);
    end
    check("seq_no_011", seen_011, 0);
    check("seq_idle", int'(busy), 0);

    // async reset while quiescing
    send_frame(17'h01021, 16);
    for (int i = 0; i < 200 && !quiesce; i++) @(negedge clk);
    check("wait_quiesce", int'(quiesce), 1);
    repeat (5) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    check("arst_major", int'(major_mode), 7);
    check("arst_quiesce", int'(quiesce), 0);
    check("arst_ready", int'(mode_ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_minor", int'(minor_cfg), 0);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b1;

    send_frame(17'h01042, 16);
    repeat (GUARD + SETTLE + 20) @(negedge clk);
    check("post_rst_major", int'(major_mode), 2);
    check("post_rst_minor", int'(minor_cfg), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
